sync_monitor: RTL and testbench

//   Interprets the receiver's SYNC~ line for the JESD204B transmitter.

---
 rtl/sync_monitor.sv | 138 +++++++++++++
 tb/tb_sync_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_monitor.sv
// sync_monitor
//   Interprets the receiver's SYNC~ line for a JESD204B transmitter. Each SYNC~
//   low period is classified as either error reporting (shorter than THR octet
//   clocks) or a link re-initialization request (THR or more). The result drives
//   the TX link controller's err-reporting / sync-request / sync-de-assertion
//   inputs, and completed error reports are counted with saturation.
//
// Ports
//   clk                  device clock, one octet per lane per cycle
//   rst_n                synchronous active-low reset
//   i_sync_n             SYNC~ from the receiver (active-low, already in clk domain)
//   i_F                  octets per frame minus one (1..256 octets)
//   i_err_cnt_clr        one-cycle strobe clearing the error counter
//   o_err_reporting      high while a SYNC~ low period is still below THR
//   o_sync_request_tx    high from request detection until SYNC~ rises
//   o_sync_de_assertion  high after a re-init SYNC~ rise until SYNC~ next goes low
//   o_err_cnt            number of completed error reports, saturating

module sync_monitor #(
    parameter int REQ_FRAMES       = 5,
    parameter int REQ_EXTRA_OCTETS = 9,
    parameter int ERR_CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sync_n,
    input  logic [7:0]           i_F,
    input  logic                 i_err_cnt_clr,
    output logic                 o_err_reporting,
    output logic                 o_sync_request_tx,
    output logic                 o_sync_de_assertion,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        SYNC_REQ = 2'd0,
        LINK_UP  = 2'd1,
        ERR_RPT  = 2'd2
    } state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    state_t      state_q, state_d;
    logic        sync_q;
    logic [11:0] thr_q, thr_d;
    logic [11:0] low_cnt_q, low_len;
    logic        err_d, req_d, de_d, inc;

    // 12 bits holds the largest threshold (5*256+9 = 1289).
    assign thr_d = 12'(REQ_FRAMES) * ({4'd0, i_F} + 12'd1) + 12'(REQ_EXTRA_OCTETS);

    // Length of the current low run including this cycle; the register keeps
    // the previous cycle's value so the comparison below sees the live length.
    always_comb begin
        low_len = 12'd0;
        if (!sync_q)
            low_len = (&low_cnt_q) ? low_cnt_q : low_cnt_q + 12'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= 1'b0;
            thr_q     <= 12'd0;
            low_cnt_q <= 12'd0;
        end else begin
            sync_q    <= i_sync_n;
            thr_q     <= thr_d;
            low_cnt_q <= low_len;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        req_d   = 1'b0;
        de_d    = o_sync_de_assertion;
        inc     = 1'b0;
        case (state_q)
            SYNC_REQ: begin
                req_d = 1'b1;
                de_d  = 1'b0;
                if (sync_q) begin
                    state_d = LINK_UP;
                    req_d   = 1'b0;
                    de_d    = 1'b1;
                end
            end
            LINK_UP: begin
                if (!sync_q) begin
                    state_d = ERR_RPT;
                    err_d   = 1'b1;
                    de_d    = 1'b0;
                end
            end
            ERR_RPT: begin
                err_d = 1'b1;
                de_d  = 1'b0;
                if (!sync_q && low_len == thr_q) begin
                    state_d = SYNC_REQ;
                    err_d   = 1'b0;
                    req_d   = 1'b1;
                end else if (sync_q) begin
                    // Short low period: an error report. de stays low so error
                    // reporting never retriggers ILA.
                    state_d = LINK_UP;
                    err_d   = 1'b0;
                    inc     = 1'b1;
                end
            end
            default: begin
                state_d = SYNC_REQ;
                req_d   = 1'b1;
                de_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= SYNC_REQ;
            o_err_reporting     <= 1'b0;
            o_sync_request_tx   <= 1'b1;
            o_sync_de_assertion <= 1'b0;
            o_err_cnt           <= '0;
        end else begin
            state_q             <= state_d;
            o_err_reporting     <= err_d;
            o_sync_request_tx   <= req_d;
            o_sync_de_assertion <= de_d;
            // Clear has priority over a coincident increment.
            if (i_err_cnt_clr)
                o_err_cnt <= '0;
            else if (inc && o_err_cnt != CNT_MAX)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_monitor.sv
// Randomized bench for sync_monitor with a run-length reference model and a
// queue-based scoreboard popped by an independent monitor process.
module tb_sync_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_sync_n = 1'b0;
    logic [7:0] i_F = 8'd1;
    logic       i_err_cnt_clr = 1'b0;
    logic       o_err_reporting, o_sync_request_tx, o_sync_de_assertion;
    logic [7:0] o_err_cnt;

    sync_monitor dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_sync_n            (i_sync_n),
        .i_F                 (i_F),
        .i_err_cnt_clr       (i_err_cnt_clr),
        .o_err_reporting     (o_err_reporting),
        .o_sync_request_tx   (o_sync_request_tx),
        .o_sync_de_assertion (o_sync_de_assertion),
        .o_err_cnt           (o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic       req;
        logic       err;
        logic       de;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;

    // reference model state
    bit m_linked, m_de, clr_pend;
    int m_run, m_cnt, thr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got req/err/de/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     name, cyc, act[10], act[9], act[8], act[7:0],
                     exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Outputs reflect the input driven two cycles earlier.
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].t <= cyc - 2) begin
                me = q.pop_front();
                chk("stream", {o_sync_request_tx, o_err_reporting, o_sync_de_assertion, o_err_cnt},
                    {me.req, me.err, me.de, me.cnt});
            end
        end
    end

    // One cycle of stimulus. A clear requested here is driven next cycle so it
    // lands together with any increment caused by this cycle's SYNC~ level.
    task automatic step(input bit s, input bit clr);
        exp_t e;
        bit   inc;
        inc = 0;
        @(negedge clk);
        i_sync_n      = s;
        i_err_cnt_clr = clr_pend;
        clr_pend      = clr;
        e.t = cyc; e.req = 0; e.err = 0;
        if (!m_linked) begin
            if (s) begin
                m_linked = 1; m_de = 1; m_run = 0;
            end else begin
                e.req = 1;
            end
        end else if (!s) begin
            m_run++;
            m_de = 0;
            if (m_run >= thr) begin
                m_linked = 0;
                e.req = 1;
            end else begin
                e.err = 1;
            end
        end else begin
            if (m_run > 0) inc = 1;
            m_run = 0;
        end
        if (clr) m_cnt = 0;
        else if (inc && m_cnt < 255) m_cnt++;
        e.de  = m_de;
        e.cnt = m_cnt[7:0];
        q.push_back(e);
    endtask

    task automatic lo(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic hi(input int n, input bit clr_first);
        for (int i = 0; i < n; i++) step(1'b1, clr_first && i == 0);
    endtask

    task automatic do_reset(input logic [7:0] f);
        @(negedge clk);
        mon_en = 0;
        q.delete();
        rst_n = 0; i_sync_n = 0; i_err_cnt_clr = 0; i_F = f;
        thr = 5 * (int'(f) + 1) + 9;
        m_linked = 0; m_de = 0; m_run = 0; m_cnt = 0; clr_pend = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", {o_sync_request_tx, o_err_reporting, o_sync_de_assertion, o_err_cnt},
                11'b100_0000_0000);
        end
        rst_n  = 1;
        mon_en = 1;
    endtask

    task automatic rand_stream(input int nseg);
        int len;
        for (int k = 0; k < nseg; k++) begin
            case ($urandom_range(0, 4))
                0: len = 1;
                1: len = thr - 1;
                2: len = thr;
                3: len = thr + int'($urandom_range(1, 5));
                default: len = int'($urandom_range(1, thr + 3));
            endcase
            lo(len);
            hi(int'($urandom_range(1, 6)), ($urandom_range(0, 7) == 0));
        end
        hi(4, 1'b0);
    endtask

    initial begin
        // THR = 19: boundary lows, coincident clear, then random runs
        do_reset(8'd1);
        lo(4); hi(3, 0);
        lo(18); hi(5, 0);
        lo(19); hi(4, 0);
        lo(18); hi(3, 1);
        rand_stream(40);

        // THR = 1289: largest threshold
        do_reset(8'd255);
        hi(2, 0);
        lo(1288); hi(3, 0);
        lo(1289); hi(3, 0);
        lo(1288); hi(3, 0);

        // THR = 14: saturate the counter, clear on an increment, reset in ERR_RPT
        do_reset(8'd0);
        hi(2, 0);
        for (int i = 0; i < 260; i++) begin
            lo(1); hi(1, 0);
        end
        lo(5); hi(2, 0);
        lo(3); hi(3, 1);
        lo(2); hi(2, 0);
        lo(4);
        repeat (3) @(negedge clk);
        do_reset(8'd3);
        rand_stream(30);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected samples left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
